fully_pipelined_subtractor: RTL and testbench
=============================================

# fully_pipelined_subtractor

- Bit-level fully pipelined ripple-borrow subtractor: one result bit resolved per stage, one new operand pair accepted every enabled cycle.
- Inverse companion to the fully pipelined adder; it sits alongside it in the arithmetic datapath and lets the bench round-trip a + b − b.
- A valid bit travels with each operand pair so downstream logic knows which outputs are real.
- A global enable stalls the whole pipeline in place.

## Interface

- WIDTH, 3, operand/result width in bits and number of pipeline stages; legal range WIDTH ≥ 1.

- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, synchronous and active-low.
- en  input  1  pipeline advance; 0 freezes every register.
- in_valid  input  1  the a/b/bin presented this cycle form a real operation.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  d/bout hold a completed result.
- d  output  WIDTH  difference, (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

## Operation

- Stage k (0..WIDTH−1) registers the following:
  - difference bits [k:0];
  - the borrow out of bit k;
  - the still-unused operand bits a[WIDTH−1:k+1] and b[WIDTH−1:k+1] (skew registers);
  - a valid bit.
- Stage 0 takes its inputs from the ports with borrow = bin. Stage k > 0 takes its inputs from stage k−1.
- Per-bit logic, with br the incoming borrow:
  - d_k = a_k ^ b_k ^ br;
  - br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br).
- Outputs d, bout and out_valid are driven directly from the stage WIDTH−1 registers. There is no combinational path from input to output.
- Data registers load on every enabled edge whatever in_valid is. out_valid only qualifies them; d/bout content is don't-care when out_valid = 0.
- en = 0: every register holds, including valid bits. Operations in flight are neither lost nor duplicated.
- rst_n = 0 at a rising edge: every register clears to 0, overriding en. After reset, out_valid = 0, d = 0, bout = 0.
- Reset mid-operation drops all in-flight operations; no partial result ever appears with out_valid = 1.
- No state machine. The valid shift chain is the only control state.

## Timing

- Latency is WIDTH enabled edges. A pair presented before enabled edge n is captured by stage 0 at edge n, and its result is visible on the outputs after edge n+WIDTH−1, i.e. WIDTH cycles after presentation.
- Stalled edges (en = 0) add 1:1 to the latency.
- Throughput is 1 operation per enabled cycle. Back-to-back pairs emerge back-to-back and in order.
- WIDTH = 1: single stage, latency 1 cycle, no skew registers.
- Wrap-around: d is always taken modulo 2^WIDTH. Overflow is reported only through bout.
- Simultaneous rst_n = 0 and en = 1: reset wins.
- Deasserting reset on the same edge as in_valid = 1: that pair is captured normally.

## Structure

- Shared package fps_pkg holds:
  - the per-bit borrow function;
  - localparam LAT = WIDTH, which the bench uses for its expected-latency model.
- Natural sub-module: subtractor_stage, parameterised by WIDTH and stage index K. It contains one full-subtractor cell plus that stage's result, skew, borrow and valid registers.
- The top instantiates WIDTH stages with a generate loop.
- The top has no logic beyond stage chaining and output assignment.

## Test plan

- All cases use WIDTH = 3 unless stated otherwise.
- Reset/idle: hold rst_n = 0 for 2 edges, then release with in_valid = 0 → out_valid = 0, d = 0, bout = 0 for all following cycles.
- Directed single ops, en = 1, each checked WIDTH cycles after presentation:
  - a=0, b=2, bin=0 → d=6, bout=1;
  - a=1, b=1, bin=1 → d=7, bout=1;
  - a=2, b=3, bin=0 → d=7, bout=1;
  - a=5, b=2, bin=1 → d=2, bout=0.
- Back-to-back: the four ops above on consecutive cycles → four consecutive out_valid = 1 cycles, in the same order with the same values, then out_valid = 0.
- Stall: drop en for 2 cycles while 2 ops are in flight → outputs and out_valid frozen during the stall; results appear exactly 2 cycles late, unchanged.
- Reset mid-flight: assert rst_n = 0 for one edge with 3 ops in flight → out_valid stays 0 until a new op completes; no stale result appears.
- Exhaustive plus WIDTH = 1:
  - WIDTH = 3: stream all 128 (a, b, bin) combinations, compare against (a − b − bin) mod 8 and the borrow.
  - WIDTH = 1: run the same check with latency 1.

Source files
------------

// File: rtl/fps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fps_pkg
//  Description : Shared definitions for the fully pipelined subtractor.
//                Holds the single-bit full-subtractor cell function used by
//                every pipeline stage, and the latency constants the
//                surrounding datapath and the bench use to line up results.
//  Contents    : DEFAULT_WIDTH - default operand width of the datapath
//                LAT           - pipeline latency in enabled cycles for the
//                                default width (one stage per result bit)
//                fs_bit_t      - {difference bit, borrow-out} of one cell
//                full_sub()    - one-bit full subtractor
//                latency()     - latency in enabled cycles for any width
//  Revision    : 1.0 - initial release
// ============================================================================
package fps_pkg;

    localparam int DEFAULT_WIDTH = 3;

    // One stage per result bit, so latency equals the operand width.
    localparam int LAT = DEFAULT_WIDTH;

    typedef struct packed {
        logic d;    // difference bit
        logic br;   // borrow out of this bit position
    } fs_bit_t;

    // Full subtractor on one bit position: a - b - br.
    // A borrow leaves this position when b exceeds a outright, or when the
    // two bits are equal and a borrow came in from below.
    function automatic fs_bit_t full_sub(
        input logic a,
        input logic b,
        input logic br
    );
        fs_bit_t r;
        r.d  = a ^ b ^ br;
        r.br = (~a & b) | (~(a ^ b) & br);
        return r;
    endfunction

    function automatic int latency(input int width);
        return width;
    endfunction

endpackage : fps_pkg
`default_nettype wire

// File: rtl/subtractor_stage.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_stage
//  Description : Stage K of the bit-level pipelined ripple-borrow subtractor.
//                Resolves difference bit K from operand bits a[K], b[K] and
//                the borrow left by stage K-1, appends it to the difference
//                bits already resolved, and carries the operand bits that
//                later stages still need (skew registers).
//  Parameters  : WIDTH - operand width of the whole subtractor
//                K     - index of this stage, 0..WIDTH-1
//  Ports       : clk      - rising-edge clock
//                rst_n    - synchronous active-low reset, overrides i_en
//                i_en     - advance; 0 holds every register of the stage
//                i_valid  - valid bit arriving from the previous stage
//                i_d      - difference bits [K-1:0] resolved upstream
//                           (1 bit wide and unused at stage 0)
//                i_a/i_b  - operand bits [WIDTH-1:K] not yet consumed;
//                           bit 0 of each is the pair used by this stage
//                i_br     - incoming borrow
//                o_d      - registered difference bits [K:0]
//                o_a/o_b  - registered operand bits [WIDTH-1:K+1]
//                           (tied to constant 0 at the last stage)
//                o_br     - registered borrow out of bit K
//                o_valid  - registered valid bit
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor_stage
    import fps_pkg::*;
#(
    parameter  int WIDTH  = 3,
    parameter  int K      = 0,
    localparam int DW_IN  = (K > 0) ? K : 1,
    localparam int AW_IN  = WIDTH - K,
    localparam int SW_OUT = (K < WIDTH - 1) ? (WIDTH - K - 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DW_IN-1:0]  i_d,
    input  logic [AW_IN-1:0]  i_a,
    input  logic [AW_IN-1:0]  i_b,
    input  logic              i_br,
    output logic [K:0]        o_d,
    output logic [SW_OUT-1:0] o_a,
    output logic [SW_OUT-1:0] o_b,
    output logic              o_br,
    output logic              o_valid
);

    fs_bit_t    w_cell;
    logic [K:0] r_d;
    logic       r_br;
    logic       r_valid;

    assign w_cell = full_sub(i_a[0], i_b[0], i_br);

    // Borrow and valid. Data registers load on every enabled edge whatever
    // the valid bit says; only the valid chain gives them meaning.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br    <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_br    <= w_cell.br;
            r_valid <= i_valid;
        end
    end

    // Difference accumulator: the new bit lands on top of the bits already
    // resolved, so bit K of the register is always this stage's result.
    generate
        if (K == 0) begin : g_d_first
            logic w_unused_d;
            assign w_unused_d = ^i_d;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_d <= '0;
                end else if (i_en) begin
                    r_d <= w_cell.d;
                end
            end
        end else begin : g_d_chain
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_d <= '0;
                end else if (i_en) begin
                    r_d <= {w_cell.d, i_d};
                end
            end
        end
    endgenerate

    // Skew registers: delay the operand bits above K so that they meet the
    // borrow for their position at the right stage. The last stage has
    // nothing left to carry.
    generate
        if (K < WIDTH - 1) begin : g_skew
            logic [SW_OUT-1:0] r_a;
            logic [SW_OUT-1:0] r_b;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (i_en) begin
                    r_a <= i_a[AW_IN-1:1];
                    r_b <= i_b[AW_IN-1:1];
                end
            end

            assign o_a = r_a;
            assign o_b = r_b;
        end else begin : g_no_skew
            assign o_a = '0;
            assign o_b = '0;
        end
    endgenerate

    assign o_d     = r_d;
    assign o_br    = r_br;
    assign o_valid = r_valid;

endmodule : subtractor_stage
`default_nettype wire

// File: rtl/fully_pipelined_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : fully_pipelined_subtractor
//  Description : Bit-level fully pipelined ripple-borrow subtractor computing
//                d = (a - b - bin) mod 2^WIDTH with borrow-out bout. One
//                result bit is resolved per stage; a new operand pair is
//                accepted on every enabled cycle and its result appears
//                WIDTH enabled edges later. A valid bit rides along with each
//                pair. en = 0 freezes the whole pipeline in place.
//  Parameters  : WIDTH     - operand/result width and stage count (>= 1)
//  Ports       : clk       - rising-edge clock
//                rst_n     - synchronous active-low reset, overrides en
//                en        - pipeline advance
//                in_valid  - a/b/bin form a real operation this cycle
//                a, b      - unsigned minuend and subtrahend
//                bin       - borrow-in
//                out_valid - d/bout hold a completed result
//                d         - difference
//                bout      - borrow-out, 1 iff a < b + bin
//  Revision    : 1.0 - initial release
// ============================================================================
module fully_pipelined_subtractor
    import fps_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    genvar k;

    generate
        for (k = 0; k < WIDTH; k++) begin : g_stage
            localparam int DW_IN  = (k > 0) ? k : 1;
            localparam int AW_IN  = WIDTH - k;
            localparam int SW_OUT = (k < WIDTH - 1) ? (WIDTH - k - 1) : 1;

            // Stage inputs
            logic [DW_IN-1:0]  w_d_in;
            logic [AW_IN-1:0]  w_a_in;
            logic [AW_IN-1:0]  w_b_in;
            logic              w_br_in;
            logic              w_valid_in;

            // Stage outputs
            logic [k:0]        w_d;
            logic [SW_OUT-1:0] w_a;
            logic [SW_OUT-1:0] w_b;
            logic              w_br;
            logic              w_valid;

            if (k == 0) begin : g_src_port
                assign w_d_in     = 1'b0;
                assign w_a_in     = a;
                assign w_b_in     = b;
                assign w_br_in    = bin;
                assign w_valid_in = in_valid;
            end else begin : g_src_prev
                assign w_d_in     = g_stage[k-1].w_d;
                assign w_a_in     = g_stage[k-1].w_a;
                assign w_b_in     = g_stage[k-1].w_b;
                assign w_br_in    = g_stage[k-1].w_br;
                assign w_valid_in = g_stage[k-1].w_valid;
            end

            // The last stage's skew outputs are constant placeholders.
            if (k == WIDTH - 1) begin : g_sink
                logic w_unused_skew;
                assign w_unused_skew = ^{w_a, w_b};
            end

            subtractor_stage #(
                .WIDTH (WIDTH),
                .K     (k)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (en),
                .i_valid (w_valid_in),
                .i_d     (w_d_in),
                .i_a     (w_a_in),
                .i_b     (w_b_in),
                .i_br    (w_br_in),
                .o_d     (w_d),
                .o_a     (w_a),
                .o_b     (w_b),
                .o_br    (w_br),
                .o_valid (w_valid)
            );
        end
    endgenerate

    // Outputs come straight from the last stage's registers.
    assign d         = g_stage[WIDTH-1].w_d;
    assign bout      = g_stage[WIDTH-1].w_br;
    assign out_valid = g_stage[WIDTH-1].w_valid;

endmodule : fully_pipelined_subtractor
`default_nettype wire

// File: tb/tb_fully_pipelined_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fully_pipelined_subtractor
//  Description : Self-checking bench for fully_pipelined_subtractor. Drives a
//                WIDTH=3 and a WIDTH=1 instance from the same stimulus. Every
//                accepted operation is turned into an expected result (plain
//                integer subtraction) with the enabled-edge count at which it
//                must appear; a separate monitor compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fully_pipelined_subtractor;
    import fps_pkg::*;

    typedef struct {
        int d;
        int bout;
        int due;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] a        = 3'd0;
    logic [2:0] b        = 3'd0;
    logic       bin      = 1'b0;

    logic       ov3;
    logic [2:0] d3;
    logic       bo3;
    logic       ov1;
    logic [0:0] d1;
    logic       bo1;

    exp_t       q[2][$];
    int         wid[2] = '{3, 1};
    logic       pov[2];
    logic [2:0] pd[2];
    logic       pb[2];

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int kind   = 3;   // 0 reset edge, 1 stalled edge, 2 enabled edge, 3 none yet

    always #5 clk = ~clk;

    fully_pipelined_subtractor #(.WIDTH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (ov3),
        .d         (d3),
        .bout      (bo3)
    );

    fully_pipelined_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a[0:0]),
        .b         (b[0:0]),
        .bin       (bin),
        .out_valid (ov1),
        .d         (d1),
        .bout      (bo1)
    );

    // Reference model: classify the edge and queue expected results.
    always @(posedge clk) begin
        if (!rst_n) begin
            kind = 0;
            q[0].delete();
            q[1].delete();
        end else if (!en) begin
            kind = 1;
        end else begin
            kind = 2;
            ecount++;
            if (in_valid) begin
                for (int i = 0; i < 2; i++) begin
                    exp_t e;
                    int   m;
                    int   diff;
                    m      = 1 << wid[i];
                    diff   = (int'(a) % m) - (int'(b) % m) - int'(bin);
                    e.d    = diff & (m - 1);
                    e.bout = (diff < 0) ? 1 : 0;
                    e.due  = ecount + latency(wid[i]) - 1;
                    q[i].push_back(e);
                end
            end
        end
    end

    task automatic check_dut(input int i, input logic ov, input logic [2:0] dv, input logic bv);
        exp_t e;
        logic exp_ov;
        if (kind == 0) begin
            checks++;
            if (ov !== 1'b0 || dv !== 3'd0 || bv !== 1'b0) begin
                errors++;
                $display("FAIL reset_w%0d: got ov=%b d=%0d bout=%b, need ov=0 d=0 bout=0", wid[i], ov, dv, bv);
            end
        end else if (kind == 1) begin
            checks++;
            if (ov !== pov[i] || dv !== pd[i] || bv !== pb[i]) begin
                errors++;
                $display("FAIL stall_w%0d: got ov=%b d=%0d bout=%b, need frozen ov=%b d=%0d bout=%b",
                         wid[i], ov, dv, bv, pov[i], pd[i], pb[i]);
            end
        end else if (kind == 2) begin
            while (q[i].size() > 0 && q[i][0].due < ecount) begin
                checks++;
                errors++;
                $display("FAIL missed_w%0d: result due at edge %0d never seen (now %0d)", wid[i], q[i][0].due, ecount);
                void'(q[i].pop_front());
            end
            exp_ov = (q[i].size() > 0 && q[i][0].due == ecount);
            checks++;
            if (ov !== exp_ov) begin
                errors++;
                $display("FAIL valid_w%0d: got out_valid=%b, need %b at edge %0d", wid[i], ov, exp_ov, ecount);
            end
            if (exp_ov) begin
                e = q[i].pop_front();
                if (ov === 1'b1) begin
                    checks++;
                    if (dv !== 3'(e.d) || bv !== 1'(e.bout)) begin
                        errors++;
                        $display("FAIL result_w%0d: got d=%0d bout=%b, need d=%0d bout=%0d",
                                 wid[i], dv, bv, e.d, e.bout);
                    end
                end
            end
        end
        pov[i] = ov;
        pd[i]  = dv;
        pb[i]  = bv;
    endtask

    always @(negedge clk) begin
        check_dut(0, ov3, d3, bo3);
        check_dut(1, ov1, {2'b00, d1}, bo1);
    end

    task automatic drive(input logic v, input logic [2:0] aa, input logic [2:0] bb, input logic bi);
        in_valid = v;
        a        = aa;
        b        = bb;
        bin      = bi;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'($urandom), 3'($urandom), 1'($urandom));
    endtask

    logic [2:0] da[4] = '{3'd0, 3'd1, 3'd2, 3'd5};
    logic [2:0] db[4] = '{3'd2, 3'd1, 3'd3, 3'd2};
    logic       dc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset held for two edges, then idle.
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        // Directed single operations.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, da[i], db[i], dc[i]);
            idle(4);
        end

        // Back-to-back.
        for (int i = 0; i < 4; i++) drive(1'b1, da[i], db[i], dc[i]);
        idle(5);

        // Stall with two operations in flight.
        drive(1'b1, da[0], db[0], dc[0]);
        drive(1'b1, da[3], db[3], dc[3]);
        en = 1'b0;
        idle(2);
        en = 1'b1;
        idle(5);

        // Reset with three operations in flight, then a fresh one.
        for (int i = 0; i < 3; i++) drive(1'b1, da[i], db[i], dc[i]);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(5);
        drive(1'b1, 3'd4, 3'd1, 1'b0);
        idle(4);

        // Reset released on the same edge that presents an operation.
        drive(1'b1, 3'd6, 3'd7, 1'b1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        drive(1'b1, 3'd7, 3'd3, 1'b1);
        idle(4);

        // Exhaustive stream of all operand combinations.
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                for (int c = 0; c < 2; c++)
                    drive(1'b1, 3'(x), 3'(y), 1'(c));
        idle(5);

        // Random traffic with random stalls.
        for (int i = 0; i < 300; i++) begin
            en = (($urandom % 4) != 0);
            drive(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
        end
        en = 1'b1;
        idle(6);

        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d results outstanding, need 0/0", q[0].size(), q[1].size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, need completion before 200000 ns");
        $fatal(1);
    end

endmodule : tb_fully_pipelined_subtractor
`default_nettype wire
